// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Long-unit results are buffered as {rd, data} entries.
package wb_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for long-latency results.
// Pointers carry an extra MSB so full and empty can be told apart.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];

  // Pointer update; push and pop may coincide at any occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; when full, the slot written is the one read out this cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback
// and buffered long-latency results, with a destination scoreboard.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             wb_hold,
  input  logic             lu_valid,
  input  logic [REG_W-1:0] lu_rd,
  input  logic [XLEN-1:0]  lu_data,
  output logic             lu_ready,
  input  logic             iss_valid,
  input  logic             iss_long,
  input  logic [REG_W-1:0] iss_rd,
  input  logic [REG_W-1:0] iss_rs1,
  input  logic [REG_W-1:0] iss_rs2,
  output logic             iss_stall,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata
);

  localparam int CW = $clog2(MAX_OUT + 1);

  wb_entry_t      head;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           iss_go;
  logic [31:0]    busy;
  logic [31:0]    busy_nxt;
  logic [CW-1:0]  out_cnt;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({lu_rd, lu_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Port selection: a full FIFO preempts WB, then WB, then idle drain.
  always_comb begin
    pop      = 1'b0;
    wb_hold  = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst_n) begin
      pop = 1'b0;
    end else if (full && wb_valid) begin
      wb_hold = 1'b1;
      pop     = 1'b1;
    end else if (wb_valid && wb_rd != '0) begin
      rf_we    = 1'b1;
      rf_waddr = wb_rd;
      rf_wdata = wb_data;
    end else if (!empty) begin
      pop = 1'b1;
    end
    if (pop && head.rd != '0) begin
      rf_we    = 1'b1;
      rf_waddr = head.rd;
      rf_wdata = head.data;
    end
  end

  // A full FIFO always pops, so a push into it is still accepted.
  assign lu_ready = rst_n && (!full || pop);
  assign push     = lu_valid && lu_ready;

  assign iss_stall = rst_n && iss_valid &&
                     (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd] ||
                      (iss_long && out_cnt == CW'(MAX_OUT)));
  assign iss_go    = iss_valid && iss_long && !iss_stall;

  // Next scoreboard: a drain clears, a new long issue sets and wins.
  always_comb begin
    busy_nxt = busy;
    if (pop) busy_nxt[head.rd] = 1'b0;
    if (iss_go && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard and outstanding long-op count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= '0;
      out_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      if (iss_go && !pop)      out_cnt <= out_cnt + CW'(1);
      else if (!iss_go && pop) out_cnt <= out_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and random checks of wb_port_arbiter against
// a queue-based reference model of the write-port rules.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int DEPTH   = 2;
  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_hold;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        iss_valid;
  logic        iss_long;
  logic [4:0]  iss_rd;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic        iss_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DEPTH   (DEPTH),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_hold   (wb_hold),
    .lu_valid  (lu_valid),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .lu_ready  (lu_ready),
    .iss_valid (iss_valid),
    .iss_long  (iss_long),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_stall (iss_stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  int n_assert = 0;
  int n_fail   = 0;

  wb_entry_t  q_m[$];
  logic [4:0] pend[$];
  bit         busy_m[32];
  int         cnt_m;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic wv,
                     input logic [4:0] wrd, input logic [31:0] wd,
                     input logic lv, input logic [4:0] lrd,
                     input logic [31:0] ld, input logic iv,
                     input logic il, input logic [4:0] ird,
                     input logic [4:0] rs1, input logic [4:0] rs2);
    logic        e_we, e_hold, e_rdy, e_stall, pop;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    wb_entry_t   h;
    @(negedge clk);
    rst_n = r; wb_valid = wv; wb_rd = wrd; wb_data = wd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    iss_valid = iv; iss_long = il; iss_rd = ird;
    iss_rs1 = rs1; iss_rs2 = rs2;
    #1;
    e_we = 0; e_hold = 0; e_rdy = 0; e_stall = 0; pop = 0;
    e_a = 0; e_d = 0;
    h = (q_m.size() > 0) ? q_m[0] : '0;
    if (r) begin
      if (q_m.size() == DEPTH && wv) begin
        e_hold = 1; pop = 1;
      end else if (wv && wrd != 0) begin
        e_we = 1; e_a = wrd; e_d = wd;
      end else if (q_m.size() > 0) begin
        pop = 1;
      end
      if (pop && h.rd != 0) begin
        e_we = 1; e_a = h.rd; e_d = h.data;
      end
      e_rdy = (q_m.size() < DEPTH) || pop;
      e_stall = iv && (busy_m[rs1] || busy_m[rs2] || busy_m[ird] ||
                       (il && cnt_m == MAX_OUT));
    end
    chk("rf_we", rf_we, e_we);
    chk("wb_hold", wb_hold, e_hold);
    chk("lu_ready", lu_ready, e_rdy);
    chk("iss_stall", iss_stall, e_stall);
    if (e_we || !r) begin
      chk("rf_waddr", rf_waddr, e_a);
      chk("rf_wdata", rf_wdata, e_d);
    end
    if (!r) begin
      q_m.delete(); pend.delete(); cnt_m = 0;
      foreach (busy_m[i]) busy_m[i] = 0;
    end else begin
      if (pop) begin
        busy_m[h.rd] = 0; cnt_m--;
        void'(q_m.pop_front());
      end
      if (lv && e_rdy) q_m.push_back('{rd: lrd, data: ld});
      if (iv && il && !e_stall) begin
        cnt_m++;
        if (ird != 0) busy_m[ird] = 1;
        pend.push_back(ird);
      end
      busy_m[0] = 0;
    end
  endtask

  logic        r_r, r_wv, r_lv, r_iv, r_il;
  logic [4:0]  r_wrd, r_lrd, r_ird, r_rs1, r_rs2;
  logic [31:0] r_wd, r_ld;

  initial begin
    rst_n = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    iss_valid = 0; iss_long = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    cnt_m = 0;

    cyc(0, 1, 4, 32'h11, 1, 2, 32'h22, 1, 1, 3, 4, 5);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    cyc(1, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pipe_we", rf_we, 1);
    chk("pipe_addr", rf_waddr, 5);
    chk("pipe_data", rf_wdata, 32'h1234);
    cyc(1, 1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pipe_rd0_we", rf_we, 0);

    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0);
    chk("long_iss", iss_stall, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 8, 7, 0);
    chk("dep_stall", iss_stall, 1);
    cyc(1, 0, 0, 0, 1, 7, 32'hDEAD, 0, 0, 0, 0, 0);
    chk("no_bypass", rf_we, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 8, 7, 0);
    chk("lu_wr_addr", rf_waddr, 7);
    chk("lu_wr_data", rf_wdata, 32'hDEAD);
    chk("dep_still", iss_stall, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 8, 7, 0);
    chk("dep_go", iss_stall, 0);

    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 10, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 11, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 12, 0, 0);
    cyc(1, 1, 3, 32'hA1, 1, 10, 32'h10A, 0, 0, 0, 0, 0);
    chk("cont_pipe0", rf_waddr, 3);
    cyc(1, 1, 3, 32'hA2, 1, 11, 32'h10B, 0, 0, 0, 0, 0);
    chk("cont_pipe1", rf_waddr, 3);
    cyc(1, 1, 3, 32'hA3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("cont_hold", wb_hold, 1);
    chk("cont_head", rf_wdata, 32'h10A);
    cyc(1, 1, 3, 32'hA4, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("cont_unhold", wb_hold, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("cont_drain", rf_waddr, 11);

    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 13, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 14, 0, 0);
    cyc(1, 1, 3, 32'hB1, 1, 12, 32'h20C, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 32'hB2, 1, 13, 32'h20D, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 14, 32'h20E, 0, 0, 0, 0, 0);
    chk("bp_ready", lu_ready, 1);
    chk("bp_pop", rf_waddr, 12);
    cyc(1, 1, 3, 32'hB3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("bp_still_full", wb_hold, 1);
    chk("bp_head", rf_waddr, 13);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("bp_last", rf_wdata, 32'h20E);

    for (int i = 1; i <= MAX_OUT; i++)
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 5'(i), 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0);
    chk("max_out", iss_stall, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 6, 9, 0);
    chk("short_go", iss_stall, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0);
    chk("waw", iss_stall, 1);

    cyc(1, 1, 20, 32'hC1, 1, 1, 32'h301, 0, 0, 0, 0, 0);
    cyc(1, 1, 20, 32'hC2, 1, 2, 32'h302, 0, 0, 0, 0, 0);
    cyc(0, 1, 20, 32'hC3, 1, 3, 32'h303, 1, 1, 9, 3, 4);
    chk("rst_we", rf_we, 0);
    chk("rst_ready", lu_ready, 0);
    cyc(0, 1, 20, 32'hC4, 0, 0, 0, 1, 0, 9, 3, 4);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 4);
    chk("post_rst_we", rf_we, 0);
    chk("post_rst_stall", iss_stall, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0);
    chk("post_rst_long", iss_stall, 0);

    for (int n = 0; n < 3000; n++) begin
      r_r   = ($urandom_range(0, 199) != 0);
      r_wv  = 1'($urandom_range(0, 1));
      r_wrd = 5'($urandom_range(0, 31));
      r_wd  = $urandom;
      r_lv  = 0; r_lrd = 0; r_ld = $urandom;
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        r_lv  = 1;
        r_lrd = pend.pop_front();
      end
      r_iv  = 1'($urandom_range(0, 1));
      r_il  = 1'($urandom_range(0, 1));
      r_ird = 5'($urandom_range(0, 7));
      r_rs1 = 5'($urandom_range(0, 7));
      r_rs2 = 5'($urandom_range(0, 7));
      cyc(r_r, r_wv, r_wrd, r_wd, r_lv, r_lrd, r_ld,
          r_iv, r_il, r_ird, r_rs1, r_rs2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
